// File: rtl/clock_div_pkg.sv
// Shared definitions for the divided-clock period meter: FSM state encoding
// and the default parameter constants used by the top level.
package clock_div_pkg;

    // Measurement FSM states; WAIT_FIRST is the post-reset / post-clear state.
    typedef enum logic [1:0] {
        ST_WAIT_FIRST = 2'd0,
        ST_MEASURE    = 2'd1,
        ST_TIMEOUT    = 2'd2
    } meas_state_t;

    // Default parameter values for clock_div_meas.
    localparam int DEF_DIV_WIDTH   = 6;
    localparam int DEF_COUNT_WIDTH = 32;
    localparam int DEF_LOCK_COUNT  = 4;
    localparam int DEF_TIMEOUT     = 1048576;

endpackage : clock_div_pkg

// File: rtl/sync_edge_det.sv
// Brings the asynchronous divided clock into the clk_in domain through a
// two-flop synchronizer and flags each rising edge with a one-cycle pulse.
// The pulse is taken combinationally from the second sync stage and the
// edge-detect flop, so the consuming logic registers it on the third clk_in
// edge after div_clk is first sampled high.
module sync_edge_det (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic edge_pulse
);

    logic [1:0] sync_r;
    logic       prev_r;

    // Two-stage metastability synchronizer.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], async_in};
        end
    end

    // Edge-detect flop holding the previous synchronized level.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= sync_r[1];
        end
    end

    assign edge_pulse = sync_r[1] & ~prev_r;

endmodule : sync_edge_det

// File: rtl/clock_div_meas.sv
// Measures the period of a divided clock in clk_in cycles, decodes the
// power-of-two division factor, tracks frequency lock and flags a stalled
// source. The counter saturates at TIMEOUT, so periods of TIMEOUT cycles or
// more are never reported; the FSM drops into ST_TIMEOUT instead.
module clock_div_meas
    import clock_div_pkg::*;
#(
    parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   div_clk,
    output logic [COUNT_WIDTH-1:0] period,
    output logic                   period_valid,
    output logic [DIV_WIDTH-1:0]   div_out,
    output logic                   div_valid,
    output logic                   locked,
    output logic                   timeout
);

    localparam int LOCK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO  = COUNT_WIDTH'(32'd0);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(32'd1);
    localparam logic [COUNT_WIDTH-1:0] CNT_LIMIT = COUNT_WIDTH'(TIMEOUT);
    localparam logic [LOCK_W-1:0]      LOCK_ZERO = LOCK_W'(32'd0);
    localparam logic [LOCK_W-1:0]      LOCK_ONE  = LOCK_W'(32'd1);
    localparam logic [LOCK_W-1:0]      LOCK_MAX  = LOCK_W'(LOCK_COUNT);
    localparam logic [DIV_WIDTH-1:0]   DIV_ZERO  = DIV_WIDTH'(32'd0);

    // Returns {valid, k}: valid when exactly one bit k >= 1 of p is set and
    // k fits the div_out range; k is forced to zero otherwise.
    function automatic logic [DIV_WIDTH:0] decode_pow2(input logic [COUNT_WIDTH-1:0] p);
        int ones;
        int pos;
        ones = 32'sd0;
        pos  = 32'sd0;
        for (int i = 32'sd0; i < COUNT_WIDTH; i++) begin
            if (p[i]) begin
                ones = ones + 32'sd1;
                pos  = i;
            end else begin
                ones = ones;
            end
        end
        if ((ones == 32'sd1) && (pos >= 32'sd1) && (pos <= ((2 ** DIV_WIDTH) - 1))) begin
            return {1'b1, DIV_WIDTH'(pos)};
        end else begin
            return {1'b0, DIV_ZERO};
        end
    endfunction

    logic                   edge_s;

    meas_state_t            state_r,        state_s;
    logic [COUNT_WIDTH-1:0] cnt_r,          cnt_s;
    logic [COUNT_WIDTH-1:0] period_r,       period_s;
    logic                   period_valid_r, period_valid_s;
    logic [DIV_WIDTH-1:0]   div_out_r,      div_out_s;
    logic                   div_valid_r,    div_valid_s;
    logic [LOCK_W-1:0]      lock_cnt_r,     lock_cnt_s;
    logic                   locked_r,       locked_s;
    logic                   timeout_r,      timeout_s;
    logic [DIV_WIDTH:0]     dec_s;

    sync_edge_det u_sync_edge_det (
        .clk_in     (clk_in),
        .rst        (rst),
        .async_in   (div_clk),
        .edge_pulse (edge_s)
    );

    // Next-state, counter, period decode and lock tracking.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        period_s       = period_r;
        period_valid_s = 1'b0;
        div_out_s      = div_out_r;
        div_valid_s    = div_valid_r;
        lock_cnt_s     = lock_cnt_r;
        locked_s       = locked_r;
        timeout_s      = timeout_r;
        dec_s          = decode_pow2(cnt_r);

        if (clr) begin
            // Restart wins over any coincident edge.
            state_s     = ST_WAIT_FIRST;
            cnt_s       = CNT_ZERO;
            period_s    = CNT_ZERO;
            div_out_s   = DIV_ZERO;
            div_valid_s = 1'b0;
            lock_cnt_s  = LOCK_ZERO;
            locked_s    = 1'b0;
            timeout_s   = 1'b0;
        end else begin
            case (state_r)
                ST_WAIT_FIRST: begin
                    if (edge_s) begin
                        // First edge only opens a measurement window.
                        cnt_s   = CNT_ONE;
                        state_s = ST_MEASURE;
                    end else begin
                        cnt_s = CNT_ZERO;
                    end
                end
                ST_MEASURE: begin
                    if (edge_s) begin
                        period_s       = cnt_r;
                        period_valid_s = 1'b1;
                        div_valid_s    = dec_s[DIV_WIDTH];
                        div_out_s      = dec_s[DIV_WIDTH-1:0];
                        cnt_s          = CNT_ONE;
                        // A zero lock count means no trusted previous period.
                        if (lock_cnt_r == LOCK_ZERO) begin
                            lock_cnt_s = LOCK_ONE;
                        end else if (cnt_r == period_r) begin
                            if (lock_cnt_r < LOCK_MAX) begin
                                lock_cnt_s = lock_cnt_r + LOCK_ONE;
                            end else begin
                                lock_cnt_s = lock_cnt_r;
                            end
                        end else begin
                            lock_cnt_s = LOCK_ONE;
                        end
                        locked_s = (lock_cnt_s == LOCK_MAX);
                    end else if (cnt_r >= (CNT_LIMIT - CNT_ONE)) begin
                        // Counter would reach TIMEOUT: declare the source stalled.
                        state_s     = ST_TIMEOUT;
                        cnt_s       = CNT_LIMIT;
                        timeout_s   = 1'b1;
                        locked_s    = 1'b0;
                        div_valid_s = 1'b0;
                        lock_cnt_s  = LOCK_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_TIMEOUT: begin
                    if (edge_s) begin
                        timeout_s = 1'b0;
                        cnt_s     = CNT_ONE;
                        state_s   = ST_MEASURE;
                    end else begin
                        cnt_s = CNT_LIMIT;
                    end
                end
                default: begin
                    state_s     = ST_WAIT_FIRST;
                    cnt_s       = CNT_ZERO;
                    div_valid_s = 1'b0;
                    lock_cnt_s  = LOCK_ZERO;
                    locked_s    = 1'b0;
                    timeout_s   = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_WAIT_FIRST;
            cnt_r          <= CNT_ZERO;
            period_r       <= CNT_ZERO;
            period_valid_r <= 1'b0;
            div_out_r      <= DIV_ZERO;
            div_valid_r    <= 1'b0;
            lock_cnt_r     <= LOCK_ZERO;
            locked_r       <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            period_r       <= period_s;
            period_valid_r <= period_valid_s;
            div_out_r      <= div_out_s;
            div_valid_r    <= div_valid_s;
            lock_cnt_r     <= lock_cnt_s;
            locked_r       <= locked_s;
            timeout_r      <= timeout_s;
        end
    end

    assign period       = period_r;
    assign period_valid = period_valid_r;
    assign div_out      = div_out_r;
    assign div_valid    = div_valid_r;
    assign locked       = locked_r;
    assign timeout      = timeout_r;

endmodule : clock_div_meas

// File: doc/clock_div_meas.md
CLOCK_DIV_MEAS -- requirements
Module: clock_div_meas

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 6, width of the decoded division factor.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32, width of the period counter and period output.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, number of consecutive identical periods required to assert locked.
REQ-004 SHALL have parameter TIMEOUT, default 1048576, number of clk_in cycles without an edge before timeout is declared.
REQ-005 SHALL have port clk_in, input, 1, the single reference clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port clr, input, 1, synchronous measurement restart.
REQ-008 SHALL have port div_clk, input, 1, divided clock under measurement, asynchronous to clk_in.
REQ-009 SHALL have port period, output, COUNT_WIDTH, last measured period in clk_in cycles.
REQ-010 SHALL have port period_valid, output, 1, one-cycle pulse marking each period update.
REQ-011 SHALL have port div_out, output, DIV_WIDTH, decoded n where period = 2**n.
REQ-012 SHALL have port div_valid, output, 1, high when period is an exact power of two with n >= 1.
REQ-013 SHALL have port locked, output, 1, stable-frequency indicator.
REQ-014 SHALL have port timeout, output, 1, no div_clk edge seen within TIMEOUT cycles.

Function
REQ-015 SHALL pass div_clk through a two-flop synchronizer and then one edge-detect flop; a rising-edge pulse (edge) occurs exactly 3 clk_in cycles after div_clk is first sampled high.
REQ-016 SHALL implement states WAIT_FIRST, MEASURE and TIMEOUT; WAIT_FIRST is the state after reset.
REQ-017 WAIT_FIRST: on edge, clear the cycle counter to 1 and go to MEASURE; no period update.
REQ-018 MEASURE: the counter increments every cycle; on edge, period <= counter, period_valid = 1 for that cycle, and the counter reloads to 1.
REQ-019 Period definition: the number of clk_in cycles between consecutive edge pulses (div_clk toggling every cycle gives 2; a 2**k divider gives 2**k).
REQ-020 div_out and div_valid SHALL update in the same cycle as period; div_valid = 1 iff exactly one bit of period is set at position k >= 1 with k <= 2**DIV_WIDTH-1, and then div_out = k; otherwise div_out = 0.
REQ-021 locked: lock counter set to 1 on the first period; incremented, saturating at LOCK_COUNT, when the new period equals the previous one; reset to 1 on a differing period; locked = (lock counter == LOCK_COUNT), updated with period.
REQ-022 MEASURE: when the counter reaches TIMEOUT with no edge, go to TIMEOUT; timeout = 1, locked = 0, div_valid = 0, lock counter = 0; period and div_out hold.
REQ-023 TIMEOUT: on edge, timeout = 0, counter = 1, go to MEASURE; the first following edge produces a fresh period (not a lock match).
REQ-024 The counter SHALL saturate and never wrap; a period >= TIMEOUT is never reported.
REQ-025 clr = 1: next state WAIT_FIRST, outputs return to reset values; clr takes priority over a coincident edge.
REQ-026 A static or div = 0 (clk_out = clk_in) source yields no edges; the block SHALL end in TIMEOUT, or stay in WAIT_FIRST if no edge was ever seen.

Reset
REQ-027 rst low SHALL asynchronously force WAIT_FIRST; synchronizer, counters and all outputs go to 0.
REQ-028 Deassertion SHALL take effect on the next clk_in edge; an in-progress period is discarded; the first edge after reset is treated per REQ-017.

Structure
REQ-029 State encoding and default parameter constants SHALL live in a shared package, clock_div_pkg.
REQ-030 The synchronizer plus edge detect SHALL be one sub-module, sync_edge_det; period decode and lock logic stay in clock_div_meas.

Verification
REQ-031 Bench SHALL drive div_clk from clock_div at div = 3 -> after the 2nd edge, period = 8, div_out = 3, div_valid = 1; locked = 1 on the 4th period.
REQ-032 Bench SHALL switch div from 3 to 5 mid-run -> locked drops on the first differing period; period = 32, div_out = 5; locked reasserts after 4 periods of 32.
REQ-033 Bench SHALL drive div_clk with a non-power-of-two period of 12 -> period = 12, div_valid = 0, div_out = 0, locked = 1 after 4 periods.
REQ-034 Bench SHALL hold div_clk low with TIMEOUT = 64 after lock -> timeout = 1 and locked = 0 at counter 64; restarting div_clk at period 4 -> timeout = 0, then period = 4.
REQ-035 Bench SHALL set div = 1 (toggle every cycle) -> period = 2, div_out = 1; set div = 0 -> no edges, timeout asserts.
REQ-036 Bench SHALL assert rst and, separately, clr mid-period -> all outputs = 0, state WAIT_FIRST, no period_valid until 2 edges after release.
